// File: rtl/passcode_pkg.sv
// Shared definitions for the 5-bit digit code: widths, FSM states and code helpers.
package passcode_pkg;

  localparam int DIGIT_W = 4;
  localparam int CODE_W  = 5;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    ERROR   = 2'd2
  } state_t;

  // Build a symbol from a BCD digit: parity bit is the XOR of the digit bits.
  function automatic logic [CODE_W-1:0] encode_digit(input logic [DIGIT_W-1:0] d);
    return {^d, d};
  endfunction

  // A symbol is well formed when it carries a BCD value and matching parity.
  function automatic logic code_is_valid(input logic [CODE_W-1:0] c);
    return (c[DIGIT_W-1:0] <= MAX_DIGIT) && (c[CODE_W-1] == ^c[DIGIT_W-1:0]);
  endfunction

endpackage

// File: rtl/passcode_decoder_code_check.sv
// Combinational symbol checker: splits a received symbol into its digit and a well-formed flag.
module code_check
  import passcode_pkg::*;
(
  input  logic [CODE_W-1:0]  code_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               ok
);

  assign digit = code_in[DIGIT_W-1:0];
  assign ok    = code_is_valid(code_in);

endmodule

// File: rtl/passcode_decoder.sv
// Passcode decoder: checks incoming digit symbols and assembles DIGITS of them into one frame.
module passcode_decoder
  import passcode_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_W-1:0]     code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   frame,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [CNT_W-1:0]      digit_count,
  output logic                  code_err
);

  localparam int FRAME_W = DIGIT_W * DIGITS;

  state_t               state_r, state_s;
  logic [FRAME_W-1:0]   frame_r, frame_s;
  logic [CNT_W-1:0]     count_r, count_s;
  logic                 err_r, err_s;
  logic                 ready_r, ready_s;
  logic                 fvalid_r, fvalid_s;
  logic [DIGIT_W-1:0]   digit_s;
  logic                 ok_s;

  code_check u_code_check (
    .code_in (code_in),
    .digit   (digit_s),
    .ok      (ok_s)
  );

  // Next-state logic; ready and frame_valid are derived from the next state so they leave as flops.
  always_comb begin
    state_s = state_r;
    frame_s = frame_r;
    count_s = count_r;
    err_s   = err_r;
    if (clear) begin
      state_s = COLLECT;
      frame_s = {FRAME_W{1'b0}};
      count_s = {CNT_W{1'b0}};
      err_s   = 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (code_valid && ready_r) begin
            if (ok_s) begin
              frame_s = (frame_r << DIGIT_W) | FRAME_W'(digit_s);
              count_s = count_r + CNT_W'(1);
              if ((count_r + CNT_W'(1)) == CNT_W'(DIGITS)) begin
                state_s = HOLD;
              end else begin
                state_s = COLLECT;
              end
            end else begin
              state_s = ERROR;
              err_s   = 1'b1;
            end
          end else begin
            state_s = COLLECT;
          end
        end
        HOLD: begin
          if (frame_ready) begin
            state_s = COLLECT;
            frame_s = {FRAME_W{1'b0}};
            count_s = {CNT_W{1'b0}};
          end else begin
            state_s = HOLD;
          end
        end
        ERROR: begin
          state_s = ERROR;
        end
        default: begin
          state_s = COLLECT;
          frame_s = {FRAME_W{1'b0}};
          count_s = {CNT_W{1'b0}};
          err_s   = 1'b0;
        end
      endcase
    end
    ready_s  = (state_s == COLLECT);
    fvalid_s = (state_s == HOLD);
  end

  // State, frame shift register, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= COLLECT;
      frame_r  <= {FRAME_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
      ready_r  <= 1'b1;
      fvalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      frame_r  <= frame_s;
      count_r  <= count_s;
      err_r    <= err_s;
      ready_r  <= ready_s;
      fvalid_r <= fvalid_s;
    end
  end

  assign code_ready  = ready_r;
  assign frame       = frame_r;
  assign frame_valid = fvalid_r;
  assign digit_count = count_r;
  assign code_err    = err_r;

endmodule
